// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_port_arbiter: owner tags, FSM encoding and the
// request bundle that is muxed onto the downstream port.
package mem_arb_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // size/wstrb/addr/wdata; req and wr travel separately.
  localparam int REQ_W = 70;

  typedef struct packed {
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_bundle_t;

endpackage

// File: rtl/owner_fifo.sv
// Synchronous FIFO holding the owner tag of every accepted memory transaction,
// so that returns can be routed back in order.
module owner_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by count, so
  // stale slots are never observed and the array maps to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and EXE requesters onto one sram-like memory port and routes
// returns by an in-order owner queue. Define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int OWNER_W     = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  arb_state_t   state, state_next;
  logic         lock_owner, lock_owner_next;
  logic         pick, sel_owner, locked_req, drop_err;
  logic         push, pop, fifo_full, fifo_empty;
  logic [OWNER_W-1:0] fifo_head;
  req_bundle_t  inst_bundle, data_bundle, mem_bundle;

  assign inst_bundle = {inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_bundle = {data_size, data_wstrb, data_addr, data_wdata};

`ifdef MEM_ARB_RR_EN
  logic last_winner;

  // On a tie, the requester that lost the previous handshake goes first.
  always_comb begin
    if (inst_req && data_req) pick = (last_winner == OWN_DATA) ? OWN_INST : OWN_DATA;
    else                      pick = data_req ? OWN_DATA : OWN_INST;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   last_winner <= OWN_INST;
    else if (push) last_winner <= sel_owner;
  end
`else
  assign pick = data_req ? OWN_DATA : OWN_INST;
`endif

  assign locked_req = (lock_owner == OWN_DATA) ? data_req : inst_req;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    lock_owner_next = lock_owner;
    sel_owner       = pick;
    mem_req         = 1'b0;
    drop_err        = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_req = resetn && (inst_req || data_req) && !fifo_full;
        if (mem_req && !mem_addr_ok) begin
          state_next      = ST_LOCK;
          lock_owner_next = pick;
        end
      end
      ST_LOCK: begin
        sel_owner = lock_owner;
        mem_req   = resetn && locked_req;
        if (!locked_req) begin
          drop_err   = 1'b1;
          state_next = ST_IDLE;
        end else if (mem_addr_ok) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      lock_owner <= OWN_INST;
      arb_err    <= 1'b0;
    end else begin
      state      <= state_next;
      lock_owner <= lock_owner_next;
      if (drop_err || (mem_data_ok && fifo_empty)) arb_err <= 1'b1;
    end
  end

  assign mem_wr     = (sel_owner == OWN_DATA) ? data_wr : inst_wr;
  assign mem_bundle = (sel_owner == OWN_DATA) ? data_bundle : inst_bundle;
  assign {mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_bundle;

  assign push         = mem_req && mem_addr_ok;
  assign inst_addr_ok = push && (sel_owner == OWN_INST);
  assign data_addr_ok = push && (sel_owner == OWN_DATA);

  owner_fifo #(.DEPTH(OUTSTANDING), .WIDTH(OWNER_W)) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (OWNER_W'(sel_owner)),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Returns with nothing outstanding are dropped and flagged via arb_err.
  assign pop          = mem_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (fifo_head[0] == OWN_INST);
  assign data_data_ok = pop && (fifo_head[0] == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule
